midi_merge_arb: RTL and testbench
=================================

MIDI_MERGE_ARB -- requirements
Module: midi_merge_arb

Interface
REQ-001 Parameter N_CH, default 4, number of MIDI input channels merged onto one uart_tx.
REQ-002 Parameter FIFO_DEPTH, default 4, per-channel byte FIFO depth; power of two, 2..16.
REQ-003 Parameter LOCK_TMO, default 1024, clk cycles a SysEx lock survives with the owner's FIFO empty.
REQ-004 Parameter ACK_TMO, default 4, clk cycles to wait for tx_busy to rise after tx_strobe.
REQ-005 clk  in  1  single system clock; all logic on posedge clk.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 rx_dat  in  8*N_CH  received bytes; channel k on bits [8k+7:8k], valid when rx_rdy[k]=1.
REQ-008 rx_rdy  in  N_CH  per-channel data-ready level from uart_rx.
REQ-009 tx_busy  in  1  uart_tx busy.
REQ-010 tx_strobe  out  1  one-cycle pulse: uart_tx loads tx_data.
REQ-011 tx_data  out  8  byte to transmit; stable from the tx_strobe cycle until the next tx_strobe.
REQ-012 grant  out  N_CH  one-hot channel currently owning the transmitter; zero when no owner.
REQ-013 ovf  out  N_CH  sticky per-channel FIFO overflow flag.
REQ-014 ovf_clr  in  N_CH  per-bit clear of ovf.

Function
REQ-015 A channel's byte SHALL be captured into its FIFO on the clk edge where rx_rdy[k] is 1 and was 0 on the previous edge (rising-edge detect); a held-high rx_rdy SHALL capture once.
REQ-016 A capture into a full FIFO SHALL drop the byte, set ovf[k], and leave FIFO contents unchanged.
REQ-017 ovf_clr[k] SHALL clear ovf[k] next edge; a simultaneous overflow and clear SHALL leave ovf[k]=1.
REQ-018 FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
REQ-019 IDLE: with tx_busy=0 and a selected channel non-empty, the FSM SHALL pop its head into tx_data, set grant, and go to ISSUE.
REQ-020 ISSUE: tx_strobe=1 for exactly this one cycle; next state WAIT_ACK.
REQ-021 WAIT_ACK: tx_busy=1 -> WAIT_DONE; after ACK_TMO cycles without tx_busy -> IDLE, byte counted as sent.
REQ-022 WAIT_DONE: tx_busy=0 -> IDLE.
REQ-023 Minimum latency: rx_rdy rising at edge n -> tx_strobe high in the cycle after edge n+2, with the FSM idle and no competition.
REQ-024 Selection without a lock SHALL be round-robin, starting at the channel after the last granted one; after reset the search starts at channel 0.
REQ-025 Message lock: a popped status byte SHALL set lock_cnt to its data-byte count: 8x,9x,Ax,Bx,Ex,F2 -> 2; Cx,Dx,F1,F3 -> 1; F0 -> SysEx lock; others -> 0.
REQ-026 While lock_cnt>0, only the locked channel SHALL be selected; each popped data byte (<0x80) decrements lock_cnt.
REQ-027 SysEx lock SHALL hold until the owner's 0xF7 is sent, or until LOCK_TMO consecutive cycles with the owner FIFO empty.
REQ-028 Real-time bytes (F8-FF) from the locked owner SHALL be sent and SHALL NOT change the lock state.
REQ-029 A data byte popped with no lock active SHALL be sent as a single byte with no lock.
REQ-030 A status byte from the owner during an active lock SHALL abort that lock and apply REQ-025 afresh.
REQ-031 grant SHALL be zero in IDLE when no lock is held; it SHALL stay asserted through the full message while locked.
REQ-032 A capture and a pop on the same FIFO in the same cycle SHALL both take effect, including when the FIFO is full.

Reset
REQ-033 On rst=1: FSM=IDLE, tx_strobe=0, tx_data=0x00, grant=0, ovf=0, all FIFOs empty, lock cleared, round-robin pointer=0, rx_rdy history=0.
REQ-034 rst asserted mid-transfer SHALL discard queued bytes and the lock; uart_tx completes any byte already strobed.

Verification
REQ-035 Ch0 sends 0x90,0x3C,0x64 while ch1 sends 0xC5,0x07 interleaved -> tx order 90 3C 64 C5 07; grant=0001 throughout the first message.
REQ-036 Ch0..ch3 each send 0xF8 in the same cycle -> tx order ch0,ch1,ch2,ch3; exactly one tx_strobe per byte.
REQ-037 5 bytes to ch2 with the FSM stalled by tx_busy=1 -> 4 sent, 5th dropped, ovf[2]=1; ovf_clr[2] pulse -> ovf[2]=0.
REQ-038 Ch1 sends 0xF0,0x7E and then stops -> grant=0010 held; after LOCK_TMO cycles grant releases and ch3's pending 0xB0 is sent.
REQ-039 tx_busy tied to 0 -> each byte returns to IDLE after ACK_TMO cycles; no deadlock.
REQ-040 rst pulsed during WAIT_DONE with 2 queued bytes -> no further tx_strobe; all outputs at reset values the next cycle.

Source files
------------

// File: rtl/midi_merge_arb.sv
// midi_merge_arb: merges N_CH MIDI byte streams onto one uart_tx.
//
// Each channel has a small byte FIFO filled on the rising edge of its rx_rdy
// level. One FSM pops a byte, hands it to uart_tx and waits for it to go out.
// Without a lock, channels are chosen round-robin. A lock keeps the transmitter
// on one channel until the current MIDI message is complete, so messages from
// different inputs are never interleaved.
//
// Ports
//   clk, rst   : system clock, synchronous active-high reset
//   rx_dat     : received bytes, channel k on [8k+7:8k]
//   rx_rdy     : per-channel data-ready level; a byte is taken on each 0->1 edge
//   tx_busy    : uart_tx busy
//   tx_strobe  : one-cycle load pulse to uart_tx
//   tx_data    : byte to send, held from tx_strobe until the next tx_strobe
//   grant      : one-hot owner of the transmitter, zero when nobody owns it
//   ovf        : sticky per-channel FIFO overflow flag
//   ovf_clr    : per-bit clear of ovf (an overflow in the same cycle wins)
//   fsm_state  : debug view of the arbiter FSM (0 IDLE, 1 ISSUE, 2 WAIT_ACK, 3 WAIT_DONE)
//
// Handshake: the receive side is edge-triggered. A byte is accepted when rx_rdy
// rises, and there is no back-pressure, so a full FIFO drops it and flags ovf.
// The transmit side is strobe/busy. tx_strobe is raised only while tx_busy is
// low. Once it is raised, the byte is considered handed over when tx_busy rises
// and falls again, or when tx_busy never rises within ACK_TMO cycles.
module midi_merge_arb #(
  parameter int N_CH       = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int LOCK_TMO   = 1024,
  parameter int ACK_TMO    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [8*N_CH-1:0] rx_dat,
  input  logic [N_CH-1:0]   rx_rdy,
  input  logic              tx_busy,
  output logic              tx_strobe,
  output logic [7:0]        tx_data,
  output logic [N_CH-1:0]   grant,
  output logic [N_CH-1:0]   ovf,
  input  logic [N_CH-1:0]   ovf_clr,
  output logic [1:0]        fsm_state
);

  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int LTW = $clog2(LOCK_TMO + 1);
  localparam int ATW = $clog2(ACK_TMO + 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_ACK  = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t state;

  // Per-channel FIFOs
  logic [7:0]    mem    [N_CH][FIFO_DEPTH];
  logic [AW-1:0] wr_ptr [N_CH];
  logic [AW-1:0] rd_ptr [N_CH];
  logic [AW:0]   cnt    [N_CH];
  logic [7:0]    head   [N_CH];

  logic [N_CH-1:0] rdy_q, cap, push, drop, pop, empty, full;

  // Arbiter state
  logic [CW-1:0]  cur_ch, rr_ptr, lock_ch, sel_ch;
  logic           sel_vld;
  logic [1:0]     lock_cnt;
  logic           sysex;
  logic           lock_act;
  logic [LTW-1:0] lock_tmr;
  logic [ATW-1:0] ack_cnt;
  logic [7:0]     pop_byte;

  // Number of data bytes that follow a status byte.
  function automatic logic [1:0] data_len(input logic [7:0] b);
    casez (b)
      8'b1000_????, 8'b1001_????, 8'b1010_????, 8'b1011_????,
      8'b1110_????, 8'hF2:                                    data_len = 2'd2;
      8'b1100_????, 8'b1101_????, 8'hF1, 8'hF3:               data_len = 2'd1;
      default:                                                data_len = 2'd0;
    endcase
  endfunction

  assign cap      = rx_rdy & ~rdy_q;
  assign lock_act = sysex | (lock_cnt != 2'd0);

  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      empty[k] = (cnt[k] == '0);
      full[k]  = (cnt[k] == (AW+1)'(FIFO_DEPTH));
      head[k]  = mem[k][rd_ptr[k]];
      // A pop in the same cycle frees a slot, so even a full FIFO accepts.
      push[k]  = cap[k] & (~full[k] | pop[k]);
      drop[k]  = cap[k] & full[k] & ~pop[k];
    end
  end

  // Channel selection. A lock pins the choice to its owner. Otherwise the
  // search starts at rr_ptr, and the loop runs backwards so that the nearest
  // non-empty channel is the one left in sel_ch.
  always_comb begin
    int j;
    j       = 0;
    sel_vld = 1'b0;
    sel_ch  = '0;
    if (lock_act) begin
      sel_vld = ~empty[lock_ch];
      sel_ch  = lock_ch;
    end else begin
      for (int i = N_CH - 1; i >= 0; i--) begin
        j = int'(rr_ptr) + i;
        if (j >= N_CH) j = j - N_CH;
        if (!empty[j]) begin
          sel_vld = 1'b1;
          sel_ch  = CW'(j);
        end
      end
    end
  end

  assign pop_byte = head[sel_ch];

  always_comb begin
    for (int k = 0; k < N_CH; k++)
      pop[k] = (state == S_IDLE) && !tx_busy && sel_vld && (sel_ch == CW'(k));
  end

  // FIFO storage needs no reset. The pointers and counts decide what is valid.
  always_ff @(posedge clk) begin
    for (int k = 0; k < N_CH; k++)
      if (push[k]) mem[k][wr_ptr[k]] <= rx_dat[8*k +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_q <= '0;
      ovf   <= '0;
      for (int k = 0; k < N_CH; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        cnt[k]    <= '0;
      end
    end else begin
      rdy_q <= rx_rdy;
      for (int k = 0; k < N_CH; k++) begin
        if (push[k]) wr_ptr[k] <= wr_ptr[k] + 1'b1;
        if (pop[k])  rd_ptr[k] <= rd_ptr[k] + 1'b1;
        case ({push[k], pop[k]})
          2'b10:   cnt[k] <= cnt[k] + 1'b1;
          2'b01:   cnt[k] <= cnt[k] - 1'b1;
          default: cnt[k] <= cnt[k];
        endcase
        if (drop[k])         ovf[k] <= 1'b1;
        else if (ovf_clr[k]) ovf[k] <= 1'b0;
      end
    end
  end

  // Arbiter FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      tx_strobe <= 1'b0;
      tx_data   <= 8'h00;
      cur_ch    <= '0;
      rr_ptr    <= '0;
      lock_ch   <= '0;
      lock_cnt  <= 2'd0;
      sysex     <= 1'b0;
      lock_tmr  <= '0;
      ack_cnt   <= '0;
    end else begin
      tx_strobe <= 1'b0;

      // A SysEx lock gives up after LOCK_TMO cycles in a row with the owner's
      // FIFO empty. That condition cannot hold while the owner is being
      // popped, so it never competes with the lock update below.
      if (sysex && empty[lock_ch]) begin
        if (lock_tmr == LTW'(LOCK_TMO - 1)) begin
          sysex    <= 1'b0;
          lock_tmr <= '0;
        end else begin
          lock_tmr <= lock_tmr + 1'b1;
        end
      end else begin
        lock_tmr <= '0;
      end

      case (state)
        S_IDLE: begin
          if (!tx_busy && sel_vld) begin
            tx_data <= pop_byte;
            cur_ch  <= sel_ch;
            rr_ptr  <= (sel_ch == CW'(N_CH - 1)) ? '0 : sel_ch + 1'b1;
            state   <= S_ISSUE;
            if (pop_byte >= 8'hF8) begin
              // Real-time byte: passes through and leaves any lock as it is.
            end else if (pop_byte[7]) begin
              // A status byte starts a new message and replaces any lock.
              // F7 ends SysEx through the default length of zero.
              lock_ch  <= sel_ch;
              lock_tmr <= '0;
              sysex    <= (pop_byte == 8'hF0);
              lock_cnt <= data_len(pop_byte);
            end else if (lock_cnt != 2'd0) begin
              lock_cnt <= lock_cnt - 2'd1;
            end
          end
        end
        S_ISSUE: begin
          tx_strobe <= 1'b1;
          ack_cnt   <= '0;
          state     <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (tx_busy)                             state   <= S_WAIT_DONE;
          else if (ack_cnt == ATW'(ACK_TMO - 1))   state   <= S_IDLE;
          else                                     ack_cnt <= ack_cnt + 1'b1;
        end
        S_WAIT_DONE: begin
          if (!tx_busy) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // While a byte is in flight, its channel owns the transmitter. In IDLE only
  // a live lock keeps a grant asserted.
  always_comb begin
    grant = '0;
    if (state != S_IDLE) grant[cur_ch]  = 1'b1;
    else if (lock_act)   grant[lock_ch] = 1'b1;
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_midi_merge_arb.sv
// Testbench for midi_merge_arb. A small uart_tx model answers tx_strobe with a
// busy pulse, and a monitor logs every strobed byte with its grant and cycle.
module tb_midi_merge_arb;

  localparam int N_CH     = 4;
  localparam int LOCK_TMO = 1024;
  localparam int ACK_TMO  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] rx_dat = '0;
  logic [3:0]  rx_rdy = '0;
  logic        tx_busy;
  logic        tx_strobe;
  logic [7:0]  tx_data;
  logic [3:0]  grant;
  logic [3:0]  ovf;
  logic [3:0]  ovf_clr = '0;
  logic [1:0]  fsm_state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // uart_tx model
  logic model_en   = 1'b1;
  logic busy_force = 1'b0;
  int   busy_len   = 3;
  int   busy_cnt   = 0;

  logic [7:0] obs_q[$];
  logic [3:0] gnt_q[$];
  int         t_q[$];

  midi_merge_arb #(
    .N_CH(N_CH), .FIFO_DEPTH(4), .LOCK_TMO(LOCK_TMO), .ACK_TMO(ACK_TMO)
  ) dut (
    .clk(clk), .rst(rst), .rx_dat(rx_dat), .rx_rdy(rx_rdy), .tx_busy(tx_busy),
    .tx_strobe(tx_strobe), .tx_data(tx_data), .grant(grant), .ovf(ovf),
    .ovf_clr(ovf_clr), .fsm_state(fsm_state)
  );

  // Clock and reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (tx_strobe)         busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = model_en ? (busy_cnt != 0) : busy_force;

  always @(negedge clk) begin
    if (tx_strobe) begin
      obs_q.push_back(tx_data);
      gnt_q.push_back(grant);
      t_q.push_back(cyc);
    end
  end

  // Driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b1;
    rx_rdy = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] mask, input logic [31:0] bytes);
    @(negedge clk);
    rx_dat = bytes;
    rx_rdy = mask;
    @(negedge clk);
    rx_rdy = '0;
  endtask

  task automatic clear_log();
    obs_q.delete();
    gnt_q.delete();
    t_q.delete();
  endtask

  task automatic wait_tx(input int n, input int max_cyc, input string name);
    int k;
    k = 0;
    while (obs_q.size() < n && k < max_cyc) begin
      @(posedge clk);
      k++;
    end
    #1;
    checks++;
    if (obs_q.size() < n) begin
      failures++;
      $display("FAIL %s: got %0d bytes, need %0d", name, obs_q.size(), n);
    end
  endtask

  // Scenarios
  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (tx_strobe !== 1'b0) begin failures++; $display("FAIL rst_strobe: got %b need 0", tx_strobe); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL rst_data: got %h need 00", tx_data); end
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL rst_grant: got %b need 0000", grant); end
    checks++; if (ovf !== 4'b0000) begin failures++; $display("FAIL rst_ovf: got %b need 0000", ovf); end
    checks++; if (fsm_state !== 2'd0) begin failures++; $display("FAIL rst_state: got %0d need 0", fsm_state); end
  endtask

  task automatic test_latency();
    clear_log();
    @(negedge clk);
    rx_dat = 32'h0000_00F8;
    rx_rdy = 4'b0001;
    @(posedge clk);                 // edge n: capture
    @(negedge clk);
    rx_rdy = '0;
    checks++; if (tx_strobe !== 1'b0) begin failures++; $display("FAIL lat_n: got %b need 0", tx_strobe); end
    @(negedge clk);                 // after edge n+1
    checks++; if (tx_strobe !== 1'b0) begin failures++; $display("FAIL lat_n1: got %b need 0", tx_strobe); end
    @(negedge clk);                 // after edge n+2
    checks++; if (tx_strobe !== 1'b1) begin failures++; $display("FAIL lat_n2: got %b need 1", tx_strobe); end
    checks++; if (tx_data !== 8'hF8) begin failures++; $display("FAIL lat_data: got %h need f8", tx_data); end
    checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL lat_grant: got %b need 0001", grant); end
    repeat (20) @(negedge clk);
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL lat_idle_grant: got %b need 0000", grant); end
  endtask

  task automatic test_interleave();
    logic [7:0] exp_b [5];
    logic [3:0] exp_g [5];
    exp_b = '{8'h90, 8'h3C, 8'h64, 8'hC5, 8'h07};
    exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010};
    clear_log();
    pulse(4'b0001, 32'h0000_0090);
    pulse(4'b0010, 32'h0000_C500);
    pulse(4'b0001, 32'h0000_003C);
    pulse(4'b0010, 32'h0000_0700);
    pulse(4'b0001, 32'h0000_0064);
    wait_tx(5, 200, "il_count");
    for (int i = 0; i < 5; i++) begin
      if (i < obs_q.size()) begin
        checks++;
        if (obs_q[i] !== exp_b[i]) begin failures++; $display("FAIL il_byte%0d: got %h need %h", i, obs_q[i], exp_b[i]); end
        checks++;
        if (gnt_q[i] !== exp_g[i]) begin failures++; $display("FAIL il_grant%0d: got %b need %b", i, gnt_q[i], exp_g[i]); end
      end
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_rt_burst();
    logic [3:0] exp_g [4];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    do_reset();
    clear_log();
    pulse(4'b1111, 32'hF8F8_F8F8);
    wait_tx(4, 200, "rt_count");
    repeat (30) @(negedge clk);
    checks++;
    if (obs_q.size() != 4) begin failures++; $display("FAIL rt_exact: got %0d strobes need 4", obs_q.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < obs_q.size()) begin
        checks++;
        if (gnt_q[i] !== exp_g[i] || obs_q[i] !== 8'hF8) begin
          failures++; $display("FAIL rt_order%0d: got %b/%h need %b/f8", i, gnt_q[i], obs_q[i], exp_g[i]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_b [4];
    exp_b = '{8'h11, 8'h12, 8'h13, 8'h14};
    clear_log();
    busy_force = 1'b1;
    model_en   = 1'b0;
    for (int i = 0; i < 5; i++) pulse(4'b0100, {8'h00, 8'h11 + 8'(i), 16'h0000});
    @(negedge clk);
    checks++; if (ovf !== 4'b0100) begin failures++; $display("FAIL ovf_set: got %b need 0100", ovf); end
    model_en = 1'b1;
    wait_tx(4, 200, "ovf_count");
    repeat (40) @(negedge clk);
    checks++;
    if (obs_q.size() != 4) begin failures++; $display("FAIL ovf_sent: got %0d bytes need 4", obs_q.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < obs_q.size()) begin
        checks++;
        if (obs_q[i] !== exp_b[i]) begin failures++; $display("FAIL ovf_byte%0d: got %h need %h", i, obs_q[i], exp_b[i]); end
      end
    end
    checks++; if (ovf !== 4'b0100) begin failures++; $display("FAIL ovf_sticky: got %b need 0100", ovf); end
    ovf_clr = 4'b0100;
    @(negedge clk);
    ovf_clr = 4'b0000;
    checks++; if (ovf !== 4'b0000) begin failures++; $display("FAIL ovf_clr: got %b need 0000", ovf); end
  endtask

  task automatic test_sysex_timeout();
    do_reset();
    clear_log();
    pulse(4'b0010, 32'h0000_F000);
    pulse(4'b0010, 32'h0000_7E00);
    wait_tx(2, 100, "sx_count");
    pulse(4'b1000, 32'hB000_0000);
    repeat (500) @(negedge clk);
    checks++; if (obs_q.size() != 2) begin failures++; $display("FAIL sx_early: got %0d bytes need 2", obs_q.size()); end
    checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL sx_hold: got %b need 0010", grant); end
    if (obs_q.size() >= 2) begin
      checks++;
      if (obs_q[0] !== 8'hF0 || obs_q[1] !== 8'h7E) begin
        failures++; $display("FAIL sx_bytes: got %h %h need f0 7e", obs_q[0], obs_q[1]);
      end
    end
    wait_tx(3, LOCK_TMO + 200, "sx_release");
    if (obs_q.size() >= 3) begin
      checks++;
      if (obs_q[2] !== 8'hB0 || gnt_q[2] !== 4'b1000) begin
        failures++; $display("FAIL sx_ch3: got %h/%b need b0/1000", obs_q[2], gnt_q[2]);
      end
    end
  endtask

  task automatic test_no_ack();
    do_reset();
    clear_log();
    model_en   = 1'b0;
    busy_force = 1'b0;
    pulse(4'b0001, 32'h0000_0020);
    pulse(4'b0001, 32'h0000_0021);
    wait_tx(2, 100, "na_count");
    if (obs_q.size() >= 2) begin
      checks++;
      if (obs_q[0] !== 8'h20 || obs_q[1] !== 8'h21) begin
        failures++; $display("FAIL na_bytes: got %h %h need 20 21", obs_q[0], obs_q[1]);
      end
      checks++;
      if (t_q[1] - t_q[0] != ACK_TMO + 2) begin
        failures++; $display("FAIL na_spacing: got %0d cycles need %0d", t_q[1] - t_q[0], ACK_TMO + 2);
      end
    end
    repeat (20) @(negedge clk);
    checks++; if (fsm_state !== 2'd0) begin failures++; $display("FAIL na_idle: got %0d need 0", fsm_state); end
    model_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    clear_log();
    busy_len = 20;
    pulse(4'b0001, 32'h0000_0030);
    pulse(4'b0001, 32'h0000_0031);
    pulse(4'b0001, 32'h0000_0032);
    wait_tx(1, 50, "rm_first");
    repeat (4) @(negedge clk);
    checks++; if (fsm_state !== 2'd3) begin failures++; $display("FAIL rm_in_done: got %0d need 3", fsm_state); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (tx_strobe !== 1'b0 || tx_data !== 8'h00 || grant !== 4'b0000 || ovf !== 4'b0000 || fsm_state !== 2'd0) begin
      failures++;
      $display("FAIL rm_outputs: got strobe=%b data=%h grant=%b ovf=%b state=%0d need 0/00/0000/0000/0",
               tx_strobe, tx_data, grant, ovf, fsm_state);
    end
    repeat (80) @(negedge clk);
    checks++; if (obs_q.size() != 1) begin failures++; $display("FAIL rm_no_more: got %0d strobes need 1", obs_q.size()); end
    busy_len = 3;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_interleave();
    test_rt_burst();
    test_overflow();
    test_sysex_timeout();
    test_no_ack();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
